// File: rtl/seg7_mmio.sv
// Memory-mapped display register block feeding the 8-digit hex tube driver.
// Optional blink support is built when SEG7_BLINK_EN is defined.
module seg7_mmio #(
  parameter int          PRESCALE_W = 24,
  parameter int          BLINK_W    = 25,
  parameter logic [31:0] ID_VALUE   = 32'h5E670016
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        busSel,
  input  logic        busWe,
  input  logic [1:0]  busAddr,
  input  logic [3:0]  busBe,
  input  logic [31:0] busWData,
  output logic [31:0] busRData,
  output logic        busReady,
  output logic [31:0] dispData,
  output logic        dispBlank
);

  typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

  state_t                r_state, w_next;
  logic [31:0]           r_data;
  logic [31:0]           r_count;
  logic [PRESCALE_W-1:0] r_presc;
  logic                  r_mode, r_freeze;
  logic                  w_blink;
  logic                  w_acc, w_wr, w_ctrl_wr, w_tick, w_clr;
  logic [31:0]           w_rdata;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    busReady = 1'b0;
    case (r_state)
      IDLE: if (busSel) w_next = ACK;
      ACK: begin
        busReady = 1'b1;
        w_next   = busSel ? HOLD : IDLE;
      end
      HOLD:    if (!busSel) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Address, direction and byte enables only matter on the IDLE->ACK edge.
  assign w_acc     = (r_state == IDLE) && busSel;
  assign w_wr      = w_acc && busWe;
  assign w_ctrl_wr = w_wr && (busAddr == 2'd1) && busBe[0];
  assign w_tick    = &r_presc;
  assign w_clr     = w_ctrl_wr && busWData[2];

  always_comb begin
    w_rdata = 32'h0;
    case (busAddr)
      2'd0: w_rdata = r_data;
      2'd1: w_rdata = {28'h0, w_blink, 1'b0, r_freeze, r_mode};
      2'd2: w_rdata = r_count;
      2'd3: w_rdata = ID_VALUE;
      default: w_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_data   <= 32'h0;
      r_count  <= 32'h0;
      r_presc  <= '0;
      r_mode   <= 1'b0;
      r_freeze <= 1'b0;
      busRData <= 32'h0;
      dispData <= 32'h0;
    end else begin
      r_presc <= r_presc + 1'b1;
      if (w_tick) r_count <= r_count + 32'd1;
      // Clear overrides a coincident prescaler wrap.
      if (w_clr) begin
        r_presc <= '0;
        r_count <= 32'h0;
      end
      if (w_acc) busRData <= w_rdata;
      if (w_wr && busAddr == 2'd0)
        for (int i = 0; i < 4; i++)
          if (busBe[i]) r_data[8*i +: 8] <= busWData[8*i +: 8];
      if (w_ctrl_wr) begin
        r_mode   <= busWData[0];
        r_freeze <= busWData[1];
      end
      if (!r_freeze) dispData <= r_mode ? r_count : r_data;
    end
  end

`ifdef SEG7_BLINK_EN
  logic [BLINK_W-1:0] r_bcnt;
  logic               r_blink_en, r_blank;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_bcnt     <= '0;
      r_blink_en <= 1'b0;
      r_blank    <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_blink_en <= busWData[3];
      if (r_blink_en) begin
        r_bcnt <= r_bcnt + 1'b1;
        if (&r_bcnt) r_blank <= ~r_blank;
      end else begin
        r_bcnt  <= '0;
        r_blank <= 1'b0;
      end
    end
  end

  assign w_blink   = r_blink_en;
  assign dispBlank = r_blank;
`else
  assign w_blink   = 1'b0;
  // Blink hardware absent: BLINK_W only shapes a constant zero here.
  assign dispBlank = |{BLINK_W{1'b0}};
`endif

endmodule

// File: tb/tb_seg7_mmio.sv
// Directed bench for seg7_mmio with a read-data scoreboard queue.
// Runs with small PRESCALE_W/BLINK_W so counter and blink timing is short.
module tb_seg7_mmio;
  localparam logic [31:0] ID = 32'h5E670016;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        busSel = 1'b0, busWe = 1'b0;
  logic [1:0]  busAddr = 2'd0;
  logic [3:0]  busBe = 4'h0;
  logic [31:0] busWData = 32'h0;
  logic [31:0] busRData, dispData;
  logic        busReady, dispBlank;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [31:0] exp_q[$];

  seg7_mmio #(.PRESCALE_W(4), .BLINK_W(3), .ID_VALUE(ID)) dut (
    .CLK(CLK), .RST(RST), .busSel(busSel), .busWe(busWe), .busAddr(busAddr),
    .busBe(busBe), .busWData(busWData), .busRData(busRData), .busReady(busReady),
    .dispData(dispData), .dispBlank(dispBlank)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns one cycle after the ack cycle.
  task automatic bus(input logic we, input logic [1:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, output logic [31:0] rd, output logic [31:0] dack);
    int n;
    busSel = 1'b1; busWe = we; busAddr = addr; busBe = be; busWData = wd;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!busReady && n < 8);
    chk("ready_hi", {31'h0, busReady}, 32'h1);
    rd   = busRData;
    dack = dispData;
    busSel = 1'b0; busWe = 1'b0; busBe = 4'h0;
    @(negedge CLK);
    chk("ready_lo", {31'h0, busReady}, 32'h0);
  endtask

  task automatic wr(input logic [1:0] addr, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] rd, dk;
    bus(1'b1, addr, be, wd, rd, dk);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    logic [31:0] rd, dk;
    exp_q.push_back(exp);
    bus(1'b0, addr, 4'h0, 32'h0, rd, dk);
    chk(tag, rd, exp_q.pop_front());
  endtask

  initial begin
    logic [31:0] rd, dk;
    int pulses;
    repeat (3) @(negedge CLK);
    chk("rst_ready", {31'h0, busReady}, 32'h0);
    chk("rst_rdata", busRData, 32'h0);
    chk("rst_disp", dispData, 32'h0);
    chk("rst_blank", {31'h0, dispBlank}, 32'h0);
    RST = 1'b1;
    @(negedge CLK);

    // DATA write/read and byte enables
    bus(1'b1, 2'd0, 4'hF, 32'h12345678, rd, dk);
    chk("disp_at_ack", dk, 32'h0);
    chk("disp_after_wr", dispData, 32'h12345678);
    rd_chk("rd_data", 2'd0, 32'h12345678);
    wr(2'd0, 4'b0101, 32'hAABBCCDD);
    rd_chk("rd_data_be", 2'd0, 32'h12BB56DD);
    wr(2'd0, 4'h0, 32'hFFFFFFFF);
    rd_chk("rd_data_be0", 2'd0, 32'h12BB56DD);

    // freeze
    wr(2'd1, 4'hF, 32'h2);
    chk("frz_disp0", dispData, 32'h12BB56DD);
    wr(2'd0, 4'hF, 32'h0000BEEF);
    chk("frz_disp1", dispData, 32'h12BB56DD);
    rd_chk("rd_ctrl_frz", 2'd1, 32'h2);
    wr(2'd1, 4'hF, 32'h0);
    chk("unfrz_disp", dispData, 32'h0000BEEF);

    // CTRL byte gate and blink
    wr(2'd1, 4'h0, 32'hFFFFFFFF);
    rd_chk("rd_ctrl_be0", 2'd1, 32'h0);
    wr(2'd1, 4'hF, 32'h8);
`ifdef SEG7_BLINK_EN
    chk("blink_e1", {31'h0, dispBlank}, 32'h0);
    repeat (6) @(negedge CLK);
    chk("blink_e7", {31'h0, dispBlank}, 32'h0);
    @(negedge CLK);
    chk("blink_e8", {31'h0, dispBlank}, 32'h1);
    repeat (7) @(negedge CLK);
    chk("blink_e15", {31'h0, dispBlank}, 32'h1);
    @(negedge CLK);
    chk("blink_e16", {31'h0, dispBlank}, 32'h0);
    rd_chk("rd_ctrl_blink", 2'd1, 32'h8);
    wr(2'd1, 4'hF, 32'h0);
    chk("blink_off", {31'h0, dispBlank}, 32'h0);
    repeat (10) @(negedge CLK);
    chk("blink_off_hold", {31'h0, dispBlank}, 32'h0);
`else
    repeat (10) @(negedge CLK);
    chk("blank_tied", {31'h0, dispBlank}, 32'h0);
    rd_chk("rd_ctrl_noblink", 2'd1, 32'h0);
    wr(2'd1, 4'hF, 32'h0);
`endif

    // COUNT mode: clear at edge E, then a clear landing on the E+32 tick
    wr(2'd1, 4'hF, 32'h5);
    chk("cnt_disp_e1", dispData, 32'h0);
    repeat (15) @(negedge CLK);
    chk("cnt_disp_e16", dispData, 32'h0);
    @(negedge CLK);
    chk("cnt_disp_e17", dispData, 32'h1);
    rd_chk("rd_count1", 2'd2, 32'h1);
    repeat (12) @(negedge CLK);
    wr(2'd1, 4'hF, 32'h5);
    chk("clr_tick_disp", dispData, 32'h0);
    rd_chk("rd_count_clr", 2'd2, 32'h0);
    wr(2'd2, 4'hF, 32'hFFFFFFFF);
    rd_chk("rd_count_ro", 2'd2, 32'h0);
    rd_chk("rd_ctrl_mode", 2'd1, 32'h1);
    wr(2'd1, 4'hF, 32'h0);
    chk("disp_data_back", dispData, 32'h0000BEEF);

    // ID read-only, long busSel hold, reset in HOLD
    wr(2'd3, 4'hF, 32'h0);
    rd_chk("rd_id", 2'd3, ID);
    exp_q.push_back(ID);
    busSel = 1'b1; busWe = 1'b0; busAddr = 2'd3;
    pulses = 0; rd = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (busReady) begin
        pulses++;
        rd = busRData;
      end
    end
    chk("hold_pulses", pulses, 32'd1);
    chk("hold_rdata", rd, exp_q.pop_front());
    RST = 1'b0;
    #1;
    chk("mid_rst_ready", {31'h0, busReady}, 32'h0);
    chk("mid_rst_rdata", busRData, 32'h0);
    chk("mid_rst_disp", dispData, 32'h0);
    chk("mid_rst_blank", {31'h0, dispBlank}, 32'h0);
    busSel = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    rd_chk("post_rst_data", 2'd0, 32'h0);
    rd_chk("post_rst_ctrl", 2'd1, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
